// File: rtl/deco_exe_pipe.sv
// Decode-to-execute pipeline register: N operand channels, valid tracking, stall hold,
// flush bubble and write-back bypass on capture and on held operands. Optional macro: DECEXE_PERF_CNT_EN.
module deco_exe_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 3,
  parameter int CTRL_W  = 8,
  parameter int PC_ADDR = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold_e,
  input  logic                     flush_e,
  input  logic                     valid_d,
  input  logic [NUM_RD*DATA_W-1:0] rd_data_d,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_d,
  input  logic [NUM_RD-1:0]        rd_used_d,
  input  logic [DATA_W-1:0]        ext_d,
  input  logic [ADDR_W-1:0]        wa3_d,
  input  logic [3:0]               cond_d,
  input  logic [CTRL_W-1:0]        ctrl_d,
  input  logic                     regwrite_d,
  input  logic                     memwrite_d,
  input  logic                     branch_d,
  input  logic                     pcsrc_d,
  input  logic [1:0]               flagw_d,
  input  logic                     regwrite_w,
  input  logic [ADDR_W-1:0]        wa3_w,
  input  logic [DATA_W-1:0]        result_w,
  output logic                     valid_e,
  output logic [NUM_RD*DATA_W-1:0] rd_data_e,
  output logic [NUM_RD*ADDR_W-1:0] rd_addr_e,
  output logic [DATA_W-1:0]        ext_e,
  output logic [ADDR_W-1:0]        wa3_e,
  output logic [3:0]               cond_e,
  output logic [CTRL_W-1:0]        ctrl_e,
  output logic                     regwrite_e,
  output logic                     memwrite_e,
  output logic                     branch_e,
  output logic                     pcsrc_e,
  output logic [1:0]               flagw_e
`ifdef DECEXE_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              bubble_cnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_ADDR);

  // Stage handshake: valid_d marks a real instruction in D; the hazard unit stalls with
  // hold_e and kills with flush_e (flush wins). valid_e marks a real instruction in E.
  logic [NUM_RD-1:0]        used_e;
  logic [NUM_RD*DATA_W-1:0] data_next;

  function automatic logic bypass_hit(input logic we, input logic used,
                                      input logic [ADDR_W-1:0] wa,
                                      input logic [ADDR_W-1:0] addr);
    return we && used && (wa == addr) && (addr != PC_A);
  endfunction

  // Operand selection for hold (repair held operands) and capture (bypass fresh operands).
  always_comb begin
    data_next = rd_data_e;
    for (int i = 0; i < NUM_RD; i++) begin
      if (hold_e) begin
        if (valid_e && bypass_hit(regwrite_w, used_e[i], wa3_w, rd_addr_e[i*ADDR_W +: ADDR_W]))
          data_next[i*DATA_W +: DATA_W] = result_w;
      end else if (bypass_hit(regwrite_w, rd_used_d[i], wa3_w, rd_addr_d[i*ADDR_W +: ADDR_W])) begin
        data_next[i*DATA_W +: DATA_W] = result_w;
      end else begin
        data_next[i*DATA_W +: DATA_W] = rd_data_d[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_e    <= 1'b0;
      rd_data_e  <= '0;
      rd_addr_e  <= '0;
      used_e     <= '0;
      ext_e      <= '0;
      wa3_e      <= '0;
      cond_e     <= '0;
      ctrl_e     <= '0;
      regwrite_e <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
      pcsrc_e    <= 1'b0;
      flagw_e    <= '0;
    end else if (flush_e) begin
      valid_e    <= 1'b0;
      rd_data_e  <= '0;
      rd_addr_e  <= '0;
      used_e     <= '0;
      ext_e      <= '0;
      wa3_e      <= '0;
      cond_e     <= '0;
      ctrl_e     <= '0;
      regwrite_e <= 1'b0;
      memwrite_e <= 1'b0;
      branch_e   <= 1'b0;
      pcsrc_e    <= 1'b0;
      flagw_e    <= '0;
    end else if (hold_e) begin
      rd_data_e  <= data_next;
    end else begin
      valid_e    <= valid_d;
      rd_data_e  <= data_next;
      rd_addr_e  <= rd_addr_d;
      used_e     <= rd_used_d;
      ext_e      <= ext_d;
      wa3_e      <= wa3_d;
      cond_e     <= cond_d;
      ctrl_e     <= ctrl_d;
      // An invalid decode slot must never cause architectural side effects.
      regwrite_e <= valid_d & regwrite_d;
      memwrite_e <= valid_d & memwrite_d;
      branch_e   <= valid_d & branch_d;
      pcsrc_e    <= valid_d & pcsrc_d;
      flagw_e    <= valid_d ? flagw_d : 2'b00;
    end
  end

`ifdef DECEXE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (flush_e) begin
        if (bubble_cnt != 32'hFFFF_FFFF) bubble_cnt <= bubble_cnt + 32'd1;
      end else if (hold_e && valid_e) begin
        if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_deco_exe_pipe.sv
// Self-checking bench for deco_exe_pipe: a reference model pushes expected E contents per edge,
// which are popped and compared after the edge. Counter checks build with DECEXE_PERF_CNT_EN.
module tb_deco_exe_pipe;

  typedef struct packed {
    logic        v;
    logic [95:0] d;
    logic [11:0] a;
    logic [31:0] x;
    logic [3:0]  w;
    logic [3:0]  c;
    logic [7:0]  k;
    logic [5:0]  s;   // {regwrite, memwrite, branch, pcsrc, flagw}
  } e_t;
  localparam int OUT_W = $bits(e_t);

  logic        clk = 1'b0;
  logic        reset;
  logic        hold_e, flush_e, valid_d;
  logic [95:0] rd_data_d;
  logic [11:0] rd_addr_d;
  logic [2:0]  rd_used_d;
  logic [31:0] ext_d;
  logic [3:0]  wa3_d, cond_d;
  logic [7:0]  ctrl_d;
  logic        regwrite_d, memwrite_d, branch_d, pcsrc_d;
  logic [1:0]  flagw_d;
  logic        regwrite_w;
  logic [3:0]  wa3_w;
  logic [31:0] result_w;
  logic        valid_e;
  logic [95:0] rd_data_e;
  logic [11:0] rd_addr_e;
  logic [31:0] ext_e;
  logic [3:0]  wa3_e, cond_e;
  logic [7:0]  ctrl_e;
  logic        regwrite_e, memwrite_e, branch_e, pcsrc_e;
  logic [1:0]  flagw_e;
`ifdef DECEXE_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
  logic [31:0] exp_stall, exp_bubble;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [OUT_W-1:0] exp_q[$];
  e_t         m;
  logic [2:0] m_used;

  // Clock / reset
  always #5 clk = ~clk;

  deco_exe_pipe dut (
    .clk(clk), .reset(reset), .hold_e(hold_e), .flush_e(flush_e), .valid_d(valid_d),
    .rd_data_d(rd_data_d), .rd_addr_d(rd_addr_d), .rd_used_d(rd_used_d), .ext_d(ext_d),
    .wa3_d(wa3_d), .cond_d(cond_d), .ctrl_d(ctrl_d), .regwrite_d(regwrite_d),
    .memwrite_d(memwrite_d), .branch_d(branch_d), .pcsrc_d(pcsrc_d), .flagw_d(flagw_d),
    .regwrite_w(regwrite_w), .wa3_w(wa3_w), .result_w(result_w), .valid_e(valid_e),
    .rd_data_e(rd_data_e), .rd_addr_e(rd_addr_e), .ext_e(ext_e), .wa3_e(wa3_e),
    .cond_e(cond_e), .ctrl_e(ctrl_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
    .branch_e(branch_e), .pcsrc_e(pcsrc_e), .flagw_e(flagw_e)
`ifdef DECEXE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: next E contents from the current inputs.
  task automatic model_edge();
    e_t n;
    logic [2:0] nu;
    logic [3:0] ad;
    n  = m;
    nu = m_used;
    if (!reset || flush_e) begin
      n  = '0;
      nu = '0;
    end else if (hold_e) begin
      for (int i = 0; i < 3; i++) begin
        ad = m.a[i*4 +: 4];
        if (m.v && regwrite_w && m_used[i] && wa3_w == ad && ad != 4'd15)
          n.d[i*32 +: 32] = result_w;
      end
    end else begin
      n.v = valid_d;
      for (int i = 0; i < 3; i++) begin
        ad = rd_addr_d[i*4 +: 4];
        if (regwrite_w && rd_used_d[i] && wa3_w == ad && ad != 4'd15)
          n.d[i*32 +: 32] = result_w;
        else
          n.d[i*32 +: 32] = rd_data_d[i*32 +: 32];
      end
      n.a = rd_addr_d;
      nu  = rd_used_d;
      n.x = ext_d;
      n.w = wa3_d;
      n.c = cond_d;
      n.k = ctrl_d;
      n.s = valid_d ? {regwrite_d, memwrite_d, branch_d, pcsrc_d, flagw_d} : 6'd0;
    end
`ifdef DECEXE_PERF_CNT_EN
    if (!reset) begin
      exp_stall  = '0;
      exp_bubble = '0;
    end else if (flush_e) begin
      if (exp_bubble != 32'hFFFF_FFFF) exp_bubble++;
    end else if (hold_e && m.v) begin
      if (exp_stall != 32'hFFFF_FFFF) exp_stall++;
    end
`endif
    m      = n;
    m_used = nu;
    exp_q.push_back(OUT_W'(n));
  endtask

  task automatic compare_out();
    e_t e;
    check_val("sb_depth", 128'(exp_q.size()), 128'd1);
    if (exp_q.size() != 0) begin
      e = e_t'(exp_q.pop_front());
      check_val("valid_e",   128'(valid_e),   128'(e.v));
      check_val("rd_data_e", 128'(rd_data_e), 128'(e.d));
      check_val("rd_addr_e", 128'(rd_addr_e), 128'(e.a));
      check_val("ext_e",     128'(ext_e),     128'(e.x));
      check_val("wa3_e",     128'(wa3_e),     128'(e.w));
      check_val("cond_e",    128'(cond_e),    128'(e.c));
      check_val("ctrl_e",    128'(ctrl_e),    128'(e.k));
      check_val("side_e",    128'({regwrite_e, memwrite_e, branch_e, pcsrc_e, flagw_e}), 128'(e.s));
    end
`ifdef DECEXE_PERF_CNT_EN
    check_val("stall_cnt",  128'(stall_cnt),  128'(exp_stall));
    check_val("bubble_cnt", 128'(bubble_cnt), 128'(exp_bubble));
`endif
  endtask

  // Driver: inputs are changed 1 time unit after a rising edge.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic clear_inputs();
    hold_e = 0; flush_e = 0; valid_d = 0;
    rd_data_d = '0; rd_addr_d = '0; rd_used_d = '0; ext_d = '0;
    wa3_d = '0; cond_d = '0; ctrl_d = '0;
    regwrite_d = 0; memwrite_d = 0; branch_d = 0; pcsrc_d = 0; flagw_d = '0;
    regwrite_w = 0; wa3_w = '0; result_w = '0;
  endtask

  task automatic rand_decode();
    valid_d   = 1'($urandom_range(0, 1));
    rd_data_d = {$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++)
      rd_addr_d[i*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
    rd_used_d = 3'($urandom_range(0, 7));
    ext_d = $urandom; wa3_d = 4'($urandom_range(0, 15));
    cond_d = 4'($urandom_range(0, 15)); ctrl_d = 8'($urandom_range(0, 255));
    {regwrite_d, memwrite_d, branch_d, pcsrc_d, flagw_d} = 6'($urandom_range(0, 63));
    regwrite_w = 1'($urandom_range(0, 1));
    wa3_w = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
    result_w = $urandom;
  endtask

  initial begin
    m = '0; m_used = '0;
`ifdef DECEXE_PERF_CNT_EN
    exp_stall = '0; exp_bubble = '0;
`endif
    reset = 0;
    clear_inputs();
    repeat (2) cycle();
    reset = 1;

    // Basic capture
    valid_d = 1; rd_data_d[31:0] = 32'h11; ext_d = 32'hABC; regwrite_d = 1;
    cycle();

    // Capture bypass: used hit, unused channel, PC address
    clear_inputs();
    valid_d = 1; rd_addr_d[7:4] = 4'd5; rd_used_d = 3'b010;
    regwrite_w = 1; wa3_w = 4'd5; result_w = 32'hDEAD;
    cycle();
    rd_used_d = 3'b000;
    cycle();
    rd_used_d = 3'b010; rd_addr_d[7:4] = 4'd15; wa3_w = 4'd15;
    cycle();

    // All channels hit the same write-back address
    rd_addr_d = {4'd6, 4'd6, 4'd6}; rd_used_d = 3'b111; wa3_w = 4'd6;
    rd_data_d = {32'h1, 32'h2, 32'h3}; result_w = 32'hCAFE;
    cycle();

    // Held-operand repair
    clear_inputs();
    valid_d = 1; rd_addr_d[3:0] = 4'd3; rd_data_d[31:0] = 32'h1; rd_used_d = 3'b001;
    ext_d = 32'h55; wa3_d = 4'd9; cond_d = 4'hE; ctrl_d = 8'hA5; regwrite_d = 1;
    cycle();
    clear_inputs();
    hold_e = 1; regwrite_w = 1; wa3_w = 4'd3; result_w = 32'h77;
    rd_data_d = {3{32'hBAD0_BAD0}}; ext_d = 32'hFFFF;
    cycle();
    regwrite_w = 0; result_w = 32'h99;
    cycle();

    // Flush beats hold
    clear_inputs();
    valid_d = 1; regwrite_d = 1; memwrite_d = 1; flagw_d = 2'b11;
    rd_data_d = {32'hA, 32'hB, 32'hC}; ext_d = 32'h1234;
    cycle();
    hold_e = 1; flush_e = 1;
    cycle();

    // Invalid decode gates side effects only
    clear_inputs();
    memwrite_d = 1; branch_d = 1; wa3_d = 4'd7; pcsrc_d = 1; flagw_d = 2'b10;
    cycle();

    // Asynchronous reset mid-run
    clear_inputs();
    valid_d = 1; rd_data_d = {32'h5, 32'h6, 32'h7}; regwrite_d = 1; ext_d = 32'h42;
    cycle();
    reset = 0;
    #2;
    m = '0; m_used = '0;
`ifdef DECEXE_PERF_CNT_EN
    exp_stall = '0; exp_bubble = '0;
`endif
    exp_q.push_back('0);
    compare_out();
    cycle();
    reset = 1;

    // Four valid stalls then two flushes
    clear_inputs();
    valid_d = 1; rd_addr_d[3:0] = 4'd2; rd_used_d = 3'b001;
    cycle();
    hold_e = 1;
    repeat (4) cycle();
    hold_e = 0; flush_e = 1;
    repeat (2) cycle();

    // Randomised traffic
    for (int k = 0; k < 200; k++) begin
      clear_inputs();
      rand_decode();
      hold_e  = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      cycle();
    end

`ifdef DECEXE_PERF_CNT_EN
    // Saturation of a preloaded stall counter
    clear_inputs();
    valid_d = 1;
    cycle();
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    exp_stall = 32'hFFFF_FFFF;
    hold_e = 1;
    repeat (2) cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
